choose_ctrl: RTL and testbench
==============================

CHOOSE_CTRL -- requirements
Module: choose_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, meaning clk cycles per cursor-blink half-period.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port scene_active  input  1  level, high while the choose scene is displayed.
REQ-005 SHALL have ports key_up, key_down, key_left, key_right  input  1 each  one-cycle key pulses.
REQ-006 SHALL have ports key_enter, key_back  input  1 each  one-cycle confirm/undo pulses.
REQ-007 SHALL have port pokemon_id  output  8  cursor slot, range 1..8; drives the choose scene.
REQ-008 SHALL have port blink  output  1  cursor highlight phase (1 = highlight shown).
REQ-009 SHALL have ports p1_sel, p2_sel  output  8 each  confirmed picks, 0 = none.
REQ-010 SHALL have port sel_done  output  1  level, high while both picks are confirmed.
REQ-011 SHALL have port reject  output  1  one-cycle pulse when an illegal confirm is ignored.

Function
REQ-012 SHALL implement FSM states IDLE, P1_PICK, P2_PICK, DONE; state, cursor, picks and blink logic all registered.
REQ-013 SHALL treat slot layout as 2 rows x 4 cols: pokemon_id = row*4 + col + 1; row 0 = ids 1-4, row 1 = ids 5-8.
REQ-014 In IDLE: pokemon_id = 1, key inputs ignored; scene_active = 1 -> P1_PICK next cycle.
REQ-015 In P1_PICK/P2_PICK: key_left col-1, wraps col 0 -> 3 in the same row; key_right col+1, wraps 3 -> 0; key_up/key_down toggle row.
REQ-016 Multiple keys in the same cycle: priority enter > back > up > down > left > right; only the winner acts.
REQ-017 P1_PICK + key_enter: p1_sel <= pokemon_id, -> P2_PICK; cursor unchanged.
REQ-018 P1_PICK + key_back: no effect.
REQ-019 P2_PICK + key_enter with pokemon_id != p1_sel: p2_sel <= pokemon_id, -> DONE.
REQ-020 P2_PICK + key_enter with pokemon_id == p1_sel: state and picks unchanged; reject = 1 for exactly that following cycle.
REQ-021 P2_PICK + key_back: p1_sel <= 0, -> P1_PICK.
REQ-022 In DONE: sel_done = 1, arrows and enter ignored; key_back clears p2_sel to 0 and -> P2_PICK.
REQ-023 scene_active = 0 in any non-IDLE state: -> IDLE next cycle; p1_sel, p2_sel cleared; cursor <= 1; priority over all keys.
REQ-024 Blink counter: 27-bit; counts 0..BLINK_DIV-1 in P1_PICK/P2_PICK; at wrap, blink toggles.
REQ-025 Any cursor move: counter <= 0 and blink <= 1 on the same edge.
REQ-026 In IDLE and DONE: counter held at 0, blink = 1.
REQ-027 sel_done SHALL be a registered decode of state == DONE (valid the cycle the FSM is in DONE).
REQ-028 pokemon_id SHALL always be within 1..8; upper bits of every 8-bit output always 0 beyond value 8.

Reset
REQ-029 While rst = 1, asynchronously: state = IDLE, pokemon_id = 1, p1_sel = p2_sel = 0, sel_done = 0, reject = 0, blink = 1, counter = 0.
REQ-030 rst asserted mid-selection SHALL discard all picks; after release the FSM restarts from IDLE and needs scene_active = 1 to proceed.

Verification
REQ-031 Reset, then scene_active = 1, right x3, right -> pokemon_id 2, 3, 4, then 1 (wrap); down -> 5; left -> 8 (wrap).
REQ-032 Cursor 3, enter -> p1_sel = 3, P2_PICK; enter at 3 -> reject pulse 1 cycle, p2_sel = 0; right, enter -> p2_sel = 4, sel_done = 1.
REQ-033 In DONE, back -> p2_sel = 0, sel_done = 0; back again -> p1_sel = 0, state P1_PICK.
REQ-034 Same-cycle enter + right at cursor 6 in P1_PICK -> p1_sel = 6, pokemon_id stays 6.
REQ-035 BLINK_DIV = 4: blink toggles every 4 cycles while idle in P1_PICK; key_left mid-period -> blink = 1 and count restarts.
REQ-036 scene_active dropped in P2_PICK, and separately rst pulsed in DONE -> state IDLE, picks 0, pokemon_id = 1, sel_done = 0.

Source files
------------

// File: rtl/choose_ctrl.sv
// choose_ctrl: two-player pick controller for the choose scene.
//
// A 2x4 cursor grid (ids 1..8) is steered by one-cycle key pulses. Player 1
// confirms a pick, then player 2 confirms a different one; back undoes the
// last confirmation. A cursor highlight blinks with a half-period of
// BLINK_DIV clocks while a pick is in progress.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   scene_active      high while the choose scene is shown
//   key_up/down/left/right, key_enter, key_back   one-cycle key pulses
//   pokemon_id        cursor slot (1..8)
//   blink             cursor highlight phase (1 = shown)
//   p1_sel, p2_sel    confirmed picks, 0 = none
//   sel_done          high while both picks are confirmed
//   reject            one-cycle pulse when a duplicate confirm is ignored
module choose_ctrl #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scene_active,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  input  logic       key_back,
  output logic [7:0] pokemon_id,
  output logic       blink,
  output logic [7:0] p1_sel,
  output logic [7:0] p2_sel,
  output logic       sel_done,
  output logic       reject
);

  typedef enum logic [1:0] {StIdle, StP1Pick, StP2Pick, StDone} state_e;

  localparam logic [26:0] BlinkLast = 27'(BLINK_DIV - 1);

  state_e      state_q, state_d;
  // Cursor index: bit 2 = row, bits 1:0 = column.
  logic [2:0]  cur_q, cur_d;
  logic [7:0]  p1_q, p1_d;
  logic [7:0]  p2_q, p2_d;
  logic        reject_q, reject_d;
  logic        sel_done_q;
  logic        blink_q, blink_d;
  logic [26:0] cnt_q, cnt_d;
  logic        move;
  logic [1:0]  col_dec, col_inc;
  logic [7:0]  cur_id;
  logic        pick_q, pick_d;

  assign cur_id  = {5'd0, cur_q} + 8'd1;
  assign col_dec = cur_q[1:0] - 2'd1;
  assign col_inc = cur_q[1:0] + 2'd1;

  // Next-state: state, cursor, picks and reject pulse.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    reject_d = 1'b0;
    move     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_d = 3'd0;
        if (scene_active) state_d = StP1Pick;
      end
      StP1Pick, StP2Pick: begin
        if (!scene_active) begin
          state_d = StIdle;
          cur_d   = 3'd0;
          p1_d    = 8'd0;
          p2_d    = 8'd0;
        end else if (key_enter) begin
          if (state_q == StP1Pick) begin
            p1_d    = cur_id;
            state_d = StP2Pick;
          end else if (cur_id != p1_q) begin
            p2_d    = cur_id;
            state_d = StDone;
          end else begin
            reject_d = 1'b1;
          end
        end else if (key_back) begin
          // Back in P1 still wins arbitration but does nothing.
          if (state_q == StP2Pick) begin
            p1_d    = 8'd0;
            state_d = StP1Pick;
          end
        end else if (key_up || key_down) begin
          cur_d = {~cur_q[2], cur_q[1:0]};
          move  = 1'b1;
        end else if (key_left) begin
          cur_d = {cur_q[2], col_dec};
          move  = 1'b1;
        end else if (key_right) begin
          cur_d = {cur_q[2], col_inc};
          move  = 1'b1;
        end
      end
      StDone: begin
        if (!scene_active) begin
          state_d = StIdle;
          cur_d   = 3'd0;
          p1_d    = 8'd0;
          p2_d    = 8'd0;
        end else if (key_back) begin
          p2_d    = 8'd0;
          state_d = StP2Pick;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pick_q = (state_q == StP1Pick) || (state_q == StP2Pick);
  assign pick_d = (state_d == StP1Pick) || (state_d == StP2Pick);

  // Blink counter only runs while staying in a pick state; entering or
  // leaving one forces a fresh period with the highlight shown.
  always_comb begin
    cnt_d   = 27'd0;
    blink_d = 1'b1;
    if (pick_q && pick_d && !move) begin
      if (cnt_q == BlinkLast) begin
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + 27'd1;
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= 3'd0;
      p1_q       <= 8'd0;
      p2_q       <= 8'd0;
      reject_q   <= 1'b0;
      sel_done_q <= 1'b0;
      blink_q    <= 1'b1;
      cnt_q      <= 27'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      reject_q   <= reject_d;
      sel_done_q <= (state_d == StDone);
      blink_q    <= blink_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pokemon_id = cur_id;
  assign blink      = blink_q;
  assign p1_sel     = p1_q;
  assign p2_sel     = p2_q;
  assign sel_done   = sel_done_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_choose_ctrl.sv
// Directed bench for choose_ctrl with a short blink period.
module tb_choose_ctrl;

  localparam logic [5:0] KEnter = 6'b100000;
  localparam logic [5:0] KBack  = 6'b010000;
  localparam logic [5:0] KUp    = 6'b001000;
  localparam logic [5:0] KDown  = 6'b000100;
  localparam logic [5:0] KLeft  = 6'b000010;
  localparam logic [5:0] KRight = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scene_active = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       key_enter = 1'b0, key_back = 1'b0;
  logic [7:0] pokemon_id, p1_sel, p2_sel;
  logic       blink, sel_done, reject;

  int passed = 0;
  int total  = 0;

  choose_ctrl #(.BLINK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .scene_active (scene_active),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_enter    (key_enter),
    .key_back     (key_back),
    .pokemon_id   (pokemon_id),
    .blink        (blink),
    .p1_sel       (p1_sel),
    .p2_sel       (p2_sel),
    .sel_done     (sel_done),
    .reject       (reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] k);
    {key_enter, key_back, key_up, key_down, key_left, key_right} = k;
    tick();
    {key_enter, key_back, key_up, key_down, key_left, key_right} = 6'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_id"},   32'(pokemon_id), 32'd1);
    check({tag, "_p1"},   32'(p1_sel),     32'd0);
    check({tag, "_p2"},   32'(p2_sel),     32'd0);
    check({tag, "_done"}, 32'(sel_done),   32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_cleared("rst");
    check("rst_reject", 32'(reject), 32'd0);
    check("rst_blink",  32'(blink),  32'd1);
    rst = 1'b0;
    tick();
    press(KRight);
    check("idle_ignore_key", 32'(pokemon_id), 32'd1);

    // Enter P1, blink timing with period 4
    scene_active = 1'b1;
    tick();
    check("p1_entry_id", 32'(pokemon_id), 32'd1);
    tick(); tick(); tick();
    check("blink_hold3", 32'(blink), 32'd1);
    tick();
    check("blink_tog0", 32'(blink), 32'd0);
    tick(); tick(); tick();
    check("blink_low3", 32'(blink), 32'd0);
    tick();
    check("blink_tog1", 32'(blink), 32'd1);
    tick(); tick(); tick(); tick();
    check("blink_tog2", 32'(blink), 32'd0);
    tick();
    press(KLeft);
    check("left_wrap_id",  32'(pokemon_id), 32'd4);
    check("move_blink_on", 32'(blink), 32'd1);
    tick(); tick(); tick();
    check("blink_restart3", 32'(blink), 32'd1);
    tick();
    check("blink_restart4", 32'(blink), 32'd0);

    // Cursor walk
    press(KRight); check("right_wrap_a", 32'(pokemon_id), 32'd1);
    press(KRight); check("right_2",      32'(pokemon_id), 32'd2);
    press(KRight); check("right_3",      32'(pokemon_id), 32'd3);
    press(KRight); check("right_4",      32'(pokemon_id), 32'd4);
    press(KRight); check("right_wrap_b", 32'(pokemon_id), 32'd1);
    press(KDown);  check("down_5",       32'(pokemon_id), 32'd5);
    press(KLeft);  check("left_wrap_8",  32'(pokemon_id), 32'd8);
    press(KUp);    check("up_4",         32'(pokemon_id), 32'd4);
    press(KLeft);  check("left_3",       32'(pokemon_id), 32'd3);

    // Picks and reject
    press(KEnter);
    check("p1_pick3", 32'(p1_sel), 32'd3);
    check("p1_keep_id", 32'(pokemon_id), 32'd3);
    press(KEnter);
    check("dup_reject", 32'(reject), 32'd1);
    check("dup_p2",     32'(p2_sel), 32'd0);
    tick();
    check("reject_pulse_end", 32'(reject), 32'd0);
    press(KRight);
    press(KEnter);
    check("p2_pick4", 32'(p2_sel),   32'd4);
    check("done_set", 32'(sel_done), 32'd1);
    press(KRight); check("done_arrow_ign", 32'(pokemon_id), 32'd4);
    press(KEnter); check("done_enter_ign", 32'(p2_sel),     32'd4);

    // Undo
    press(KBack);
    check("back_p2_clr",  32'(p2_sel),   32'd0);
    check("back_done_lo", 32'(sel_done), 32'd0);
    check("back_p1_keep", 32'(p1_sel),   32'd3);
    press(KBack);
    check("back_p1_clr", 32'(p1_sel), 32'd0);
    press(KEnter);
    check("p1_again", 32'(p1_sel), 32'd4);
    check("p1_again_p2", 32'(p2_sel), 32'd0);
    press(KBack);
    check("back_to_p1", 32'(p1_sel), 32'd0);

    // Priority
    press(KDown);  press(KRight); press(KRight);
    check("cursor_6", 32'(pokemon_id), 32'd6);
    press(KEnter | KRight);
    check("prio_enter_p1", 32'(p1_sel),     32'd6);
    check("prio_enter_id", 32'(pokemon_id), 32'd6);
    press(KLeft | KRight);
    check("prio_left", 32'(pokemon_id), 32'd5);
    press(KBack | KUp);
    check("prio_back_p1", 32'(p1_sel),     32'd0);
    check("prio_back_id", 32'(pokemon_id), 32'd5);
    press(KBack | KRight);
    check("p1_back_noop", 32'(pokemon_id), 32'd5);

    // Scene drop in P2
    press(KEnter);
    check("p1_pick5", 32'(p1_sel), 32'd5);
    scene_active = 1'b0;
    tick();
    check_cleared("scene_drop");
    check("scene_drop_blink", 32'(blink), 32'd1);

    // Async reset in DONE, restart requires scene_active
    scene_active = 1'b1;
    tick();
    press(KEnter);
    press(KRight);
    press(KEnter);
    check("done2_p2",   32'(p2_sel),   32'd2);
    check("done2_flag", 32'(sel_done), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    scene_active = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    press(KEnter);
    check("post_rst_idle", 32'(p1_sel), 32'd0);
    scene_active = 1'b1;
    tick();
    press(KEnter);
    check("post_rst_pick", 32'(p1_sel), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end

endmodule
